// File: rtl/thermostat_ctrl.sv
// Thermostat controller: hysteresis heat/cool FSM with compressor lockout and sensor watchdog.
// Define THERMO_COOL_EN to build the COOL state and cool_on drive; otherwise heating only.
module thermostat_ctrl #(
    parameter int unsigned SP_DEFAULT  = 22,
    parameter int unsigned SP_MIN      = 10,
    parameter int unsigned SP_MAX      = 35,
    parameter int unsigned HYST        = 1,
    parameter int unsigned MIN_OFF_CYC = 100_000_000,
    parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [7:0] temp_data,
    input  logic       temp_valid,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] setpoint,
    output logic       heat_on,
    output logic       cool_on,
    output logic       fan_on,
    output logic [2:0] state,
    output logic       sensor_fault
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEAT    = 3'd1;
`ifdef THERMO_COOL_EN
    localparam logic [2:0] ST_COOL    = 3'd2;
`endif
    localparam logic [2:0] ST_LOCKOUT = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    localparam int LW = $clog2(MIN_OFF_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(MIN_OFF_CYC - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);
    localparam logic [8:0]    HYST9     = 9'(HYST);
    localparam logic [7:0]    SP_MIN8   = 8'(SP_MIN);
    localparam logic [7:0]    SP_MAX8   = 8'(SP_MAX);
    localparam logic [7:0]    SP_DEF8   = 8'(SP_DEFAULT);

    logic [7:0]    temp_q_r;
    logic          have_sample_r;
    logic          valid_q_r;
    logic [LW-1:0] lock_cnt_r;
    logic [WW-1:0] wd_cnt_r;
    logic [2:0]    next_state_s;
    logic [7:0]    sp_next_s;
    logic [8:0]    temp9_s;
    logic [8:0]    sp9_s;
    logic          heat_req_s;
    logic          wd_expire_s;
`ifdef THERMO_COOL_EN
    logic          cool_req_s;
`endif

    // Widen to 9 bits so setpoint +/- HYST can never wrap.
    assign temp9_s     = {1'b0, temp_q_r};
    assign sp9_s       = {1'b0, setpoint};
    assign heat_req_s  = have_sample_r && ((temp9_s + HYST9) <= sp9_s);
`ifdef THERMO_COOL_EN
    assign cool_req_s  = have_sample_r && (temp9_s >= (sp9_s + HYST9));
`endif
    // A sample arriving in the expiry cycle rescues the sensor.
    assign wd_expire_s = (wd_cnt_r == WD_LAST) && !temp_valid;

    // Next-state selection; watchdog expiry overrides every state.
    always_comb begin
        next_state_s = state;
        if (wd_expire_s) begin
            next_state_s = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (heat_req_s) begin
                        next_state_s = ST_HEAT;
`ifdef THERMO_COOL_EN
                    end else if (cool_req_s) begin
                        next_state_s = ST_COOL;
`endif
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_HEAT: begin
                    if (temp9_s >= sp9_s) next_state_s = ST_LOCKOUT;
                    else                  next_state_s = ST_HEAT;
                end
`ifdef THERMO_COOL_EN
                ST_COOL: begin
                    if (temp9_s <= sp9_s) next_state_s = ST_LOCKOUT;
                    else                  next_state_s = ST_COOL;
                end
`endif
                ST_LOCKOUT: begin
                    if (lock_cnt_r == LOCK_LAST) next_state_s = ST_IDLE;
                    else                         next_state_s = ST_LOCKOUT;
                end
                ST_FAULT: begin
                    if (valid_q_r) next_state_s = ST_LOCKOUT;
                    else           next_state_s = ST_FAULT;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Saturating setpoint adjust; both buttons together cancel.
    always_comb begin
        sp_next_s = setpoint;
        if (btn_up && !btn_down && (setpoint < SP_MAX8)) begin
            sp_next_s = setpoint + 8'd1;
        end else if (btn_down && !btn_up && (setpoint > SP_MIN8)) begin
            sp_next_s = setpoint - 8'd1;
        end else begin
            sp_next_s = setpoint;
        end
    end

    // Sample capture and one-cycle delayed strobe for FAULT exit.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            temp_q_r      <= 8'd0;
            have_sample_r <= 1'b0;
            valid_q_r     <= 1'b0;
        end else begin
            valid_q_r <= temp_valid;
            if (temp_valid) begin
                temp_q_r      <= temp_data;
                have_sample_r <= 1'b1;
            end
        end
    end

    // Sensor watchdog, saturating at the expiry value.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n)                wd_cnt_r <= '0;
        else if (temp_valid)         wd_cnt_r <= '0;
        else if (wd_cnt_r != WD_LAST) wd_cnt_r <= wd_cnt_r + WW'(1);
    end

    // Lockout timer runs only while staying in LOCKOUT, so it is zero on entry.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            lock_cnt_r <= '0;
        end else if ((state == ST_LOCKOUT) && (next_state_s == ST_LOCKOUT)) begin
            lock_cnt_r <= lock_cnt_r + LW'(1);
        end else begin
            lock_cnt_r <= '0;
        end
    end

    // Setpoint register.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) setpoint <= SP_DEF8;
        else          setpoint <= sp_next_s;
    end

    // State and drive outputs, decoded from the next state so they align with state.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            heat_on      <= 1'b0;
            cool_on      <= 1'b0;
            fan_on       <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            state        <= next_state_s;
            heat_on      <= (next_state_s == ST_HEAT);
`ifdef THERMO_COOL_EN
            cool_on      <= (next_state_s == ST_COOL);
            fan_on       <= (next_state_s == ST_HEAT) || (next_state_s == ST_COOL);
`else
            cool_on      <= 1'b0;
            fan_on       <= (next_state_s == ST_HEAT);
`endif
            sensor_fault <= (next_state_s == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl with short lockout (8) and watchdog (64) timings.
module tb_thermostat_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic [7:0] temp_data  = 8'd0;
    logic       temp_valid = 1'b0;
    logic       btn_up     = 1'b0;
    logic       btn_down   = 1'b0;
    logic [7:0] setpoint;
    logic       heat_on;
    logic       cool_on;
    logic       fan_on;
    logic [2:0] state;
    logic       sensor_fault;

    int checks = 0;
    int errors = 0;

    thermostat_ctrl #(
        .SP_DEFAULT (22),
        .SP_MIN     (10),
        .SP_MAX     (35),
        .HYST       (1),
        .MIN_OFF_CYC(8),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset_n     (reset_n),
        .temp_data   (temp_data),
        .temp_valid  (temp_valid),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .setpoint    (setpoint),
        .heat_on     (heat_on),
        .cool_on     (cool_on),
        .fan_on      (fan_on),
        .state       (state),
        .sensor_fault(sensor_fault)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] t);
        temp_data  = t;
        temp_valid = 1'b1;
        tick(1);
        temp_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sp", 32'(setpoint), 32'd22);
        chk("rst_heat", 32'(heat_on), 32'd0);
        chk("rst_cool", 32'(cool_on), 32'd0);
        chk("rst_fan", 32'(fan_on), 32'd0);
        chk("rst_fault", 32'(sensor_fault), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Heat cycle: 20 < 22-1 heats on the second edge
        send(8'd20);
        chk("heat_latency", 32'(state), 32'd0);
        tick(1);
        chk("heat_state", 32'(state), 32'd1);
        chk("heat_on", 32'(heat_on), 32'd1);
        chk("heat_fan", 32'(fan_on), 32'd1);
        chk("heat_cool_off", 32'(cool_on), 32'd0);
        send(8'd22);
        tick(1);
        chk("heat_to_lock", 32'(state), 32'd3);
        chk("lock_heat_off", 32'(heat_on), 32'd0);
        chk("lock_fan_off", 32'(fan_on), 32'd0);
        tick(7);
        chk("lock_hold7", 32'(state), 32'd3);
        tick(1);
        chk("lock_to_idle", 32'(state), 32'd0);
        tick(1);
        chk("idle_at_sp", 32'(state), 32'd0);

`ifdef THERMO_COOL_EN
        // Cool cycle and heat request held off by lockout
        send(8'd24);
        tick(1);
        chk("cool_state", 32'(state), 32'd2);
        chk("cool_on", 32'(cool_on), 32'd1);
        chk("cool_fan", 32'(fan_on), 32'd1);
        chk("cool_heat_off", 32'(heat_on), 32'd0);
        send(8'd22);
        tick(1);
        chk("cool_to_lock", 32'(state), 32'd3);
        chk("cool_lock_off", 32'(cool_on), 32'd0);
        send(8'd21);
        chk("lock_ignore21", 32'(state), 32'd3);
        tick(6);
        chk("lock_ignore_late", 32'(state), 32'd3);
        chk("lock_no_heat", 32'(heat_on), 32'd0);
        tick(1);
        chk("lock2_to_idle", 32'(state), 32'd0);
        tick(1);
        chk("idle_then_heat", 32'(state), 32'd1);
`else
        // Heating-only build never cools
        send(8'd40);
        tick(2);
        chk("nocool_idle", 32'(state), 32'd0);
        chk("nocool_cool_off", 32'(cool_on), 32'd0);
        chk("nocool_fan_off", 32'(fan_on), 32'd0);
        send(8'd21);
        tick(1);
        chk("nocool_heat", 32'(state), 32'd1);
`endif

        // Watchdog timeout from HEAT
        send(8'd21);
        tick(62);
        chk("wd_pre62", 32'(state), 32'd1);
        tick(1);
        chk("wd_pre63", 32'(state), 32'd1);
        tick(1);
        chk("wd_fault", 32'(state), 32'd4);
        chk("wd_sensor_fault", 32'(sensor_fault), 32'd1);
        chk("wd_heat_off", 32'(heat_on), 32'd0);
        chk("wd_fan_off", 32'(fan_on), 32'd0);
        send(8'd21);
        chk("fault_hold", 32'(state), 32'd4);
        tick(1);
        chk("fault_to_lock", 32'(state), 32'd3);
        chk("fault_cleared", 32'(sensor_fault), 32'd0);
        tick(8);
        chk("fault_lock_idle", 32'(state), 32'd0);
        tick(1);
        chk("reheat", 32'(state), 32'd1);

        // Sample in the expiry cycle wins
        send(8'd21);
        tick(63);
        send(8'd21);
        chk("wd_rescue", 32'(state), 32'd1);
        chk("wd_rescue_flt", 32'(sensor_fault), 32'd0);
        tick(1);
        chk("wd_rescue2", 32'(state), 32'd1);

        // Reset mid-HEAT
        reset_n = 1'b0;
        tick(1);
        chk("rsth_state", 32'(state), 32'd0);
        chk("rsth_heat", 32'(heat_on), 32'd0);
        chk("rsth_fan", 32'(fan_on), 32'd0);
        chk("rsth_cool", 32'(cool_on), 32'd0);
        chk("rsth_fault", 32'(sensor_fault), 32'd0);
        chk("rsth_sp", 32'(setpoint), 32'd22);
        reset_n = 1'b1;
        tick(2);
        chk("rsth_no_sample", 32'(state), 32'd0);

        // Setpoint change takes effect mid-HEAT
        send(8'd20);
        tick(1);
        chk("sp_heat", 32'(state), 32'd1);
        btn_down = 1'b1;
        tick(2);
        btn_down = 1'b0;
        chk("sp_dn2", 32'(setpoint), 32'd20);
        chk("sp_still_heat", 32'(state), 32'd1);
        tick(1);
        chk("sp_to_lock", 32'(state), 32'd3);

        // Reset mid-LOCKOUT aborts it
        tick(3);
        reset_n = 1'b0;
        tick(1);
        chk("rstl_state", 32'(state), 32'd0);
        chk("rstl_sp", 32'(setpoint), 32'd22);
        reset_n = 1'b1;
        tick(1);
        chk("rstl_idle", 32'(state), 32'd0);

        // Setpoint saturation and simultaneous press
        btn_up = 1'b1;
        tick(20);
        btn_up = 1'b0;
        chk("sp_max", 32'(setpoint), 32'd35);
        send(8'd30);
        btn_down = 1'b1;
        tick(30);
        btn_down = 1'b0;
        chk("sp_min", 32'(setpoint), 32'd10);
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(1);
        chk("sp_both_min", 32'(setpoint), 32'd10);
        btn_down = 1'b0;
        tick(1);
        chk("sp_up1", 32'(setpoint), 32'd11);
        btn_down = 1'b1;
        tick(2);
        btn_up = 1'b0;
        btn_down = 1'b0;
        chk("sp_both", 32'(setpoint), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thermostat_ctrl.md
THERMOSTAT_CTRL -- requirements
Module: thermostat_ctrl

Interface
REQ-001 Parameter SP_DEFAULT, 22: setpoint after reset, degrees C.
REQ-002 Parameter SP_MIN, 10: lowest allowed setpoint, degrees C.
REQ-003 Parameter SP_MAX, 35: highest allowed setpoint, degrees C.
REQ-004 Parameter HYST, 1: hysteresis band, degrees C.
REQ-005 Parameter MIN_OFF_CYC, 100_000_000: lockout duration in clock cycles.
REQ-006 Parameter TIMEOUT_CYC, 200_000_000: sensor watchdog limit in clock cycles.
REQ-007 clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-008 reset_n  input  1  reset, synchronous, active-low.
REQ-009 temp_data  input  8  unsigned Celsius sample from the I2C master.
REQ-010 temp_valid  input  1  one-cycle strobe; temp_data is valid in this cycle.
REQ-011 btn_up  input  1  one-cycle debounced pulse; raises the setpoint.
REQ-012 btn_down  input  1  one-cycle debounced pulse; lowers the setpoint.
REQ-013 setpoint  output  8  current setpoint, degrees C, registered.
REQ-014 heat_on  output  1  heater drive, registered.
REQ-015 cool_on  output  1  cooler drive, registered.
REQ-016 fan_on  output  1  fan drive, registered; equals heat_on OR cool_on.
REQ-017 state  output  3  FSM state: IDLE=0, HEAT=1, COOL=2, LOCKOUT=3, FAULT=4.
REQ-018 sensor_fault  output  1  high only while the FSM is in FAULT.

Function
REQ-019 On temp_valid, temp_q SHALL capture temp_data at that edge, and have_sample SHALL set to 1.
REQ-020 The FSM SHALL evaluate temp_q on the edge after capture, so outputs change on the second rising edge after temp_valid.
REQ-021 Setpoint SHALL increment on btn_up when below SP_MAX, decrement on btn_down when above SP_MIN, and otherwise saturate.
REQ-022 Simultaneous btn_up and btn_down SHALL leave the setpoint unchanged.
REQ-023 All comparisons SHALL use 9-bit unsigned arithmetic, so setpoint-HYST and setpoint+HYST never wrap.
REQ-024 IDLE SHALL go to HEAT when have_sample=1 and temp_q+HYST <= setpoint.
REQ-025 IDLE SHALL go to COOL when have_sample=1 and temp_q >= setpoint+HYST; HEAT is impossible in that case, so no priority is needed.
REQ-026 HEAT SHALL go to LOCKOUT when temp_q >= setpoint.
REQ-027 COOL SHALL go to LOCKOUT when temp_q <= setpoint.
REQ-028 Setpoint changes SHALL apply to the comparison on the next cycle, including mid-HEAT and mid-COOL.
REQ-029 LOCKOUT SHALL drive all outputs off, count exactly MIN_OFF_CYC cycles, then go to IDLE; the counter SHALL clear on LOCKOUT entry.
REQ-030 The watchdog counter SHALL clear on every temp_valid and otherwise increment, saturating at the limit.
REQ-031 When the watchdog reaches TIMEOUT_CYC-1 without a temp_valid, every state SHALL go to FAULT on the next edge.
REQ-032 FAULT SHALL force heat_on, cool_on and fan_on to 0 and set sensor_fault=1.
REQ-033 FAULT SHALL go to LOCKOUT on the edge after the next temp_valid.
REQ-034 A temp_valid in the same cycle the watchdog expires SHALL win: no FAULT entry.
REQ-035 heat_on SHALL be 1 only in HEAT and cool_on only in COOL; both SHALL never be 1 together.

Reset
REQ-036 While reset_n=0 at a clock edge, the block SHALL set: state=IDLE, setpoint=SP_DEFAULT, heat_on=0, cool_on=0, fan_on=0, sensor_fault=0, temp_q=0, have_sample=0, all counters=0.
REQ-037 A reset mid-HEAT or mid-LOCKOUT SHALL abort immediately, with no lockout honoured afterwards.

Configuration
REQ-038 With macro THERMO_COOL_EN defined, the COOL state and cool_on drive SHALL be implemented as above.
REQ-039 Without THERMO_COOL_EN, the COOL state SHALL be absent, cool_on SHALL be tied to 0, and IDLE SHALL never leave for COOL; heating, lockout and fault behaviour are unchanged.

Verification (bench uses MIN_OFF_CYC=8, TIMEOUT_CYC=64, THERMO_COOL_EN defined)
REQ-040 Reset, then temp_valid with temp_data=20 -> on the 2nd edge state=HEAT, heat_on=1, fan_on=1; then temp_data=22 -> state=LOCKOUT, and after 8 cycles state=IDLE.
REQ-041 temp_data=24 -> COOL with cool_on=1; then temp_data=22 -> LOCKOUT; temp_data=21 during LOCKOUT -> no HEAT until IDLE is re-entered.
REQ-042 Press btn_up 20 times from 22 -> setpoint=35; press btn_down 30 times -> setpoint=10; simultaneous up+down -> unchanged.
REQ-043 No temp_valid for 64 cycles while in HEAT -> state=FAULT, sensor_fault=1, heat_on=0; then temp_valid -> LOCKOUT.
REQ-044 Drive temp_valid in the watchdog-expiry cycle -> no FAULT; assert reset_n=0 mid-HEAT -> all outputs match REQ-036 on the next edge.
REQ-045 Compile without THERMO_COOL_EN and drive temp_data=40 -> state stays IDLE and cool_on=0.
